// File: rtl/matrix_h_pkg.sv
// Shared constants, word type and contents of the 4x4 complex channel matrix H.
// Plane 0 holds the real parts and plane 1 the imaginary parts. Each plane
// holds 16 signed Q3.12 words, where 0x1000 = +1.0, row-major (k = 4*i + j).
package matrix_h_pkg;

  localparam int WIDTH     = 16;
  localparam int COLL      = 16;
  localparam int DEPTH     = 2;
  localparam int COLL_LOG  = (COLL  > 1) ? $clog2(COLL)  : 1;
  localparam int DEPTH_LOG = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic signed [WIDTH-1:0] h_word_t;

  localparam h_word_t H_ROM [DEPTH][COLL] = '{
    // Real plane
    '{16'h1000, 16'hF800, 16'h0400, 16'hFC00,
      16'h0C00, 16'h1000, 16'hF400, 16'h0200,
      16'hFE00, 16'h0600, 16'h1000, 16'hF000,
      16'h0800, 16'hFA00, 16'h0300, 16'h1000},
    // Imaginary plane
    '{16'h0000, 16'h0400, 16'hFC00, 16'h0800,
      16'hF800, 16'h0000, 16'h0600, 16'hFE00,
      16'h0200, 16'hF600, 16'h0000, 16'h0C00,
      16'hFC00, 16'h0A00, 16'hF200, 16'h0000}
  };

endpackage

// File: rtl/matrix_h_rom_if.sv
// Read port of the H matrix store. The reader drives a plane select (row) and
// an element index (collum) every cycle; there is no valid/ready handshake:
// an address presented at a rising edge is always accepted, and the word for
// it appears on data_out after the configured read latency.
interface matrix_h_rom_if;
  import matrix_h_pkg::*;

  logic [DEPTH_LOG-1:0] row;
  logic [COLL_LOG-1:0]  collum;
  h_word_t              data_out;

  modport master (output row, output collum, input  data_out);
  modport slave  (input  row, input  collum, output data_out);

endinterface

// File: rtl/matrix_h_rom.sv
// Registered lookup into the constant H matrix table.
// Read latency is 1 cycle; defining MATRIX_H_OUT_REG_EN adds a second output
// register (latency 2) for timing closure into downstream multipliers.
// Both stages clear to 0 asynchronously while rst is high.
// Out-of-range plane or element addresses read as 0.
module matrix_h_rom
  import matrix_h_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  matrix_h_rom_if.slave  bus
);

  h_word_t data_d;
  h_word_t data_q;

  // Table lookup for the presented address; anything outside the table reads 0.
  always_comb begin
    data_d = '0;
    if ((int'(bus.row) < DEPTH) && (int'(bus.collum) < COLL)) begin
      data_d = H_ROM[bus.row][bus.collum];
    end
  end

  // First read stage: capture the looked-up word every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

`ifdef MATRIX_H_OUT_REG_EN
  generate
    begin : g_out_reg
      h_word_t out_d;
      h_word_t out_q;

      // Second stage simply retimes the first-stage word.
      always_comb begin
        out_d = data_q;
      end

      // Second read stage register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q <= '0;
        end else begin
          out_q <= out_d;
        end
      end

      assign bus.data_out = out_q;
    end
  endgenerate
`else
  assign bus.data_out = data_q;
`endif

endmodule

// File: tb/tb_matrix_h_rom.sv
// Directed bench for matrix_h_rom: two instances (plane 0 and plane 1) share
// one element address. Expected words come from the bench's own copy of the
// H tables, pushed into per-plane expected queues and popped after the
// configured latency (2 with MATRIX_H_OUT_REG_EN, else 1).
module tb_matrix_h_rom;

`ifdef MATRIX_H_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  matrix_h_rom_if bus_re ();
  matrix_h_rom_if bus_im ();

  matrix_h_rom u_re (.clk(clk), .rst(rst), .bus(bus_re));
  matrix_h_rom u_im (.clk(clk), .rst(rst), .bus(bus_im));

  assign bus_re.row = 1'b0;
  assign bus_im.row = 1'b1;

  logic [3:0] col;
  assign bus_re.collum = col;
  assign bus_im.collum = col;

  // Hand-entered reference tables
  logic [15:0] re_tab [16] = '{
    16'h1000, 16'hF800, 16'h0400, 16'hFC00,
    16'h0C00, 16'h1000, 16'hF400, 16'h0200,
    16'hFE00, 16'h0600, 16'h1000, 16'hF000,
    16'h0800, 16'hFA00, 16'h0300, 16'h1000};
  logic [15:0] im_tab [16] = '{
    16'h0000, 16'h0400, 16'hFC00, 16'h0800,
    16'hF800, 16'h0000, 16'h0600, 16'hFE00,
    16'h0200, 16'hF600, 16'h0000, 16'h0C00,
    16'hFC00, 16'h0A00, 16'hF200, 16'h0000};

  // Scoreboard
  logic [15:0] exp_re_q[$];
  logic [15:0] exp_im_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pipeline stages cleared by reset hold 0, so refill the queues with zeros.
  task automatic flush_sb();
    exp_re_q.delete();
    exp_im_q.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      exp_re_q.push_back(16'h0000);
      exp_im_q.push_back(16'h0000);
    end
  endtask

  // Driver: present an address, clock it in, then check what has matured.
  task automatic step(input logic [3:0] c, input string tag);
    col = c;
    @(posedge clk);
    #1;
    exp_re_q.push_back(re_tab[c]);
    exp_im_q.push_back(im_tab[c]);
    if (exp_re_q.size() >= LAT) begin
      check_eq({tag, "_re"}, bus_re.data_out, exp_re_q.pop_front());
      check_eq({tag, "_im"}, bus_im.data_out, exp_im_q.pop_front());
    end
  endtask

  // Stimulus
  initial begin
    col = 4'd9;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_re", bus_re.data_out, 16'h0000);
    check_eq("rst_im", bus_im.data_out, 16'h0000);

    // Release with collum = 0
    col = 4'd0;
    rst = 1'b0;
    flush_sb();
    step(4'd0, "first");
    for (int i = 0; i < LAT - 1; i++) step(4'd0, "first_hold");

    // Spot checks
    step(4'd6,  "spot6");
    step(4'd13, "spot13");
    for (int i = 0; i < LAT; i++) step(4'd13, "spot13_hold");

    // Sweep 0..15 then hold at 15
    for (int k = 0; k < 16; k++) step(4'(k), "sweep");
    for (int i = 0; i < 3; i++) step(4'd15, "hold15");

    // Async reset between edges in the middle of a sweep
    for (int k = 0; k < 7; k++) step(4'(k), "pre_arst");
    #3 rst = 1'b1;
    #1;
    check_eq("arst_re", bus_re.data_out, 16'h0000);
    check_eq("arst_im", bus_im.data_out, 16'h0000);
    @(posedge clk);
    #1;
    check_eq("arst_hold_re", bus_re.data_out, 16'h0000);
    check_eq("arst_hold_im", bus_im.data_out, 16'h0000);
    rst = 1'b0;
    flush_sb();
    for (int k = 7; k < 16; k++) step(4'(k), "resume");

    // Random addresses
    for (int n = 0; n < 200; n++) step(4'($urandom_range(0, 15)), "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
